// File: rtl/fifo_pkg.sv
// Shared defaults, the FIFO operation encoding and a width helper for the
// button-driven FIFO.
package fifo_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_ADDR_W    = 2;
   localparam int DEF_DB_CYCLES = 4;

   // Accepted-operation code, {write, read}.
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_BOTH = 2'b11
   } op_e;

   // Bits needed to hold values 0 .. value-1, never less than one.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push button to clean one-clock press pulse: 2-FF synchroniser,
// stability counter, registered rising-edge detector.
module btn_debounce
   import fifo_pkg::*;
#(
   parameter int DB_CYCLES = DEF_DB_CYCLES
) (
   input  logic clk,
   input  logic clr,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_pulse
);

   localparam int            CW   = clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          level_q;

   // NOTE: every register here uses <= so all stages sample the values from
   // before the edge; blocking assignments would collapse the pipeline.
   always_ff @(posedge clk) begin
      if (clr) begin
         sync      <= '0;
         cnt       <= '0;
         btn_level <= 1'b0;
         level_q   <= 1'b0;
         btn_pulse <= 1'b0;
      end else begin
         sync      <= {sync[0], btn_raw};
         level_q   <= btn_level;
         btn_pulse <= btn_level & ~level_q;
         // Any sample that agrees with the accepted level restarts the count.
         if (sync[1] != btn_level) begin
            if (cnt == LAST) begin
               btn_level <= sync[1];
               cnt       <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/fifo_btn_buffer.sv
// Push-button FIFO: one debounced press of the write/read button performs
// exactly one push/pop, with level flags and sticky over/underflow flags.
module fifo_btn_buffer
   import fifo_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DB_CYCLES  = DEF_DB_CYCLES,
   parameter int AF_LEVEL   = 3,
   parameter int AE_LEVEL   = 1,
   parameter int SHOW_AHEAD = 0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              button_wrd,
   input  logic              button_red,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] r_data,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              ovf,
   output logic              udf
);

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W + 1)'(AE_LEVEL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wptr, rptr;
   logic              wr_pulse, rd_pulse;
   logic [1:0]        unused_levels;
   logic              do_wr, do_rd;
   op_e               op;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_wr_btn (
      .clk(clk), .clr(clr), .btn_raw(button_wrd),
      .btn_level(unused_levels[0]), .btn_pulse(wr_pulse)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_rd_btn (
      .clk(clk), .clr(clr), .btn_raw(button_red),
      .btn_level(unused_levels[1]), .btn_pulse(rd_pulse)
   );

   assign full         = (count == FULL_CNT);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_CNT);
   assign almost_empty = (count <= AE_CNT);

   // A simultaneous pop frees the slot, so a write into a full FIFO proceeds.
   assign do_wr = wr_pulse & (~full | rd_pulse);
   assign do_rd = rd_pulse & ~empty;
   assign op    = op_e'({do_wr, do_rd});

   always_ff @(posedge clk) begin
      if (clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) rptr <= rptr + 1'b1;
         if (wr_pulse && full && !rd_pulse) ovf <= 1'b1;
         if (rd_pulse && empty) udf <= 1'b1;
         case (op)
            OP_WR:   count <= count + 1'b1;
            OP_RD:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: the storage array has no reset; only pointers and count are cleared,
   // which keeps it a plain RAM and leaves old contents unreachable.
   always_ff @(posedge clk) begin
      if (do_wr && !clr) mem[wptr] <= data;
   end

   generate
      if (SHOW_AHEAD != 0) begin : g_show_ahead
         assign r_data = mem[rptr];
      end else begin : g_registered
         always_ff @(posedge clk) begin
            if (clr)        r_data <= '0;
            else if (do_rd) r_data <= mem[rptr];
         end
      end
   endgenerate

endmodule
